// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, handshaked 8-op ALU with multi-cycle variable shifts.
//
// Operations (op): 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 NOT, 101 XOR,
//                  110 LSR, 111 LSL.
// Flags: fZ zero, fC carry, fN negative, fP positive (non-zero, non-negative).
//
// Parameters:
//   WIDTH            datapath width (power of two, >= 4)
//   SHIFT_PER_CYCLE  max bit positions moved per SHIFT cycle (1..WIDTH)
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   operand handshake; rs/rt/op (and cin_sel) sampled on accept
//   rs, rt, op       operands and opcode; shifts take amount from rt[SHAMT_W-1:0]
//   out_valid/ready  result handshake; rd and flags hold while stalled
//   rd               registered result
//   fZ fC fN fP      registered flags, updated together with rd
//   busy             high while a shift is in progress
//
// Optional feature (macro ALU_ADC_EN): adds input cin_sel. With cin_sel=1,
// ADD/SUB use the stored fC (value at accept time) as carry-in.
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH           = 16,
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       op,
`ifdef ALU_ADC_EN
  input  logic             cin_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             fZ,
  output logic             fC,
  output logic             fN,
  output logic             fP,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  // One extra bit so a full SHIFT_PER_CYCLE == WIDTH step is representable.
  localparam int STEP_W  = SHAMT_W + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011,
    OP_NOT = 3'b100, OP_XOR = 3'b101, OP_LSR = 3'b110, OP_LSL = 3'b111
  } op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state;
  logic [WIDTH-1:0]   work;        // shift operand in flight; rd holds the old result
  logic [SHAMT_W-1:0] rem;         // bit positions still to shift
  logic               shift_left;

  op_e                op_in;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               accept;

  assign op_in    = op_e'(op);
  assign shamt    = rt[SHAMT_W-1:0];
  assign is_shift = (op_in == OP_LSR) || (op_in == OP_LSL);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU result for non-shift ops and zero-amount shifts.
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    alu_res = '0;
    alu_c   = 1'b0;
`ifdef ALU_ADC_EN
    cin = cin_sel ? fC : (op_in == OP_SUB);
`else
    cin = (op_in == OP_SUB);
`endif
    // SUB is rs + ~rt + 1, so the carry out means "no borrow" (rs >= rt).
    sum = {1'b0, rs} + {1'b0, (op_in == OP_SUB) ? ~rt : rt} + {{WIDTH{1'b0}}, cin};
    case (op_in)
      OP_ADD, OP_SUB: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_AND:         alu_res = rs & rt;
      OP_ORR:         alu_res = rs | rt;
      OP_NOT:         alu_res = ~rs;
      OP_XOR:         alu_res = rs ^ rt;
      default:        alu_res = rs;   // shift by zero passes rs through, fC = 0
    endcase
  end

  // One SHIFT-cycle step: move min(SHIFT_PER_CYCLE, rem) positions.
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] rem_after;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH-1:0]  pre_last;     // shifted by step-1: the last bit out sits at the edge
  logic              shift_out;

  always_comb begin
    step      = ({1'b0, rem} < STEP_W'(SHIFT_PER_CYCLE)) ? {1'b0, rem}
                                                         : STEP_W'(SHIFT_PER_CYCLE);
    rem_after = {1'b0, rem} - step;
    shifted   = shift_left ? (work << step) : (work >> step);
    pre_last  = shift_left ? (work << (step - STEP_W'(1))) : (work >> (step - STEP_W'(1)));
    shift_out = shift_left ? pre_last[WIDTH-1] : pre_last[0];
  end

  // Value and carry loaded into rd/fC on entry to DONE.
  logic [WIDTH-1:0] next_rd;
  logic             next_c;

  assign next_rd = (state == SHIFT) ? shifted   : alu_res;
  assign next_c  = (state == SHIFT) ? shift_out : alu_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd         <= '0;
      fZ         <= 1'b0;
      fC         <= 1'b0;
      fN         <= 1'b0;
      fP         <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      work       <= '0;
      rem        <= '0;
      shift_left <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every read sees the pre-edge value.
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state      <= SHIFT;
              busy       <= 1'b1;
              out_valid  <= 1'b0;
              work       <= rs;
              rem        <= shamt;
              shift_left <= (op_in == OP_LSL);
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              rd        <= next_rd;
              fC        <= next_c;
              fZ        <= (next_rd == '0);
              fN        <= next_rd[WIDTH-1];
              fP        <= (next_rd != '0) && !next_rd[WIDTH-1];
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          work <= shifted;
          rem  <= rem_after[SHAMT_W-1:0];
          if (rem_after == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            rd        <= next_rd;
            fC        <= next_c;
            fZ        <= (next_rd == '0);
            fN        <= next_rd[WIDTH-1];
            fP        <= (next_rd != '0) && !next_rd[WIDTH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
